// File: rtl/ir_queue.sv
// ir_queue: instruction register backed by a DEPTH-entry prefetch FIFO.
// Fetched words arrive over a valid/ready handshake. The sequencer consumes
// the head word with an adv pulse. The head word is decoded into its
// instruction fields.
module ir_queue #(
  parameter int W     = 16,
  parameter int OPW   = 6,
  parameter int DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [W-1:0]                  in,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic                          adv,
  input  logic                          flush,
  output logic                          out_valid,
  output logic [W-1:0]                  out,
  output logic [OPW-1:0]                opcode,
  output logic                          RA,
  output logic [W-OPW-1:0]              BA,
  output logic [W-OPW-2:0]              IMM,
  output logic [1:0]                    RA_stack,
  output logic [W-1:0]                  imm_sext,
  output logic [$clog2(DEPTH+1)-1:0]    count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  logic [DEPTH-1:0][W-1:0] r_mem;
  logic [AW-1:0]           r_wptr, r_rptr;
  logic [CW-1:0]           r_count;
  logic                    w_push, w_pop;
  logic [W-1:0]            w_head;

  // Handshake status depends only on registered occupancy, so adv never
  // reaches in_ready combinationally.
  assign in_ready  = (r_count != FULL);
  assign out_valid = (r_count != '0);
  assign count     = r_count;

  // Flush discards both sides of the handshake in the same cycle.
  assign w_push = in_valid && in_ready && !flush;
  assign w_pop  = adv && out_valid && !flush;

  // Stale entries stay in memory after a pop or flush. They are masked here.
  assign w_head = out_valid ? r_mem[r_rptr] : '0;
  assign out    = w_head;

  assign opcode   = w_head[W-1:W-OPW];
  assign RA       = w_head[W-OPW-1];
  assign BA       = w_head[W-OPW-1:0];
  assign IMM      = w_head[W-OPW-2:0];
  assign RA_stack = w_head[W-OPW-1:W-OPW-2];
  assign imm_sext = {{(OPW+1){w_head[W-OPW-2]}}, w_head[W-OPW-2:0]};

  // Storage write: only the entry under the write pointer changes.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)         r_mem         <= '0;
    else if (w_push) r_mem[r_wptr] <= in;
  end

  // Pointer and occupancy update. Flush has priority over push and pop.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else if (flush) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + AW'(1);
      if (w_pop)  r_rptr <= r_rptr + AW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: doc/ir_queue.md
# ir_queue

Parametrised instruction register with a DEPTH-entry prefetch queue and field decode. Fetched instruction words enter through a valid/ready handshake and are held in FIFO order. The sequencer consumes the head word with a one-cycle `adv` pulse. The head word is decoded into opcode, RA, BA, IMM, RA_stack and a sign-extended immediate. It sits between instruction memory and the control unit, replacing the single-word IR and adding buffering, handshake and flush.

## Interface
- `W`, 16: instruction word width; minimum OPW+3.
- `OPW`, 6: opcode width; opcode = word[W-1:W-OPW].
- `DEPTH`, 4: queue entries; power of two, at least 2.
- `clk` in 1: single clock; all state updates on the rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `in` in W: fetched instruction word.
- `in_valid` in 1: `in` carries a word to load.
- `in_ready` out 1: the queue can accept a word; equals count < DEPTH.
- `adv` in 1: consume the head word this cycle.
- `flush` in 1: synchronous discard of all entries (branch/jump).
- `out_valid` out 1: the queue is non-empty; equals count != 0.
- `out` out W: head word; all zeros when the queue is empty.
- `opcode` out OPW: out[W-1:W-OPW].
- `RA` out 1: out[W-OPW-1].
- `BA` out W-OPW: out[W-OPW-1:0].
- `IMM` out W-OPW-1: out[W-OPW-2:0].
- `RA_stack` out 2: out[W-OPW-1:W-OPW-2].
- `imm_sext` out W: IMM sign-extended to W bits from bit W-OPW-2.
- `count` out $clog2(DEPTH+1): number of occupied entries.

## Operation
- Storage: DEPTH×W register array with write pointer `wptr`, read pointer `rptr` and `count`.
  - Each pointer is $clog2(DEPTH) bits wide and wraps naturally from DEPTH-1 to 0.
- Push: occurs when in_valid && in_ready && !flush.
  - Writes `in` to mem[wptr], then increments wptr.
- Pop: occurs when adv && out_valid && !flush.
  - Increments rptr.
  - `adv` while empty is ignored; there is no underflow and no state change.
- Count update:
  - push only: count+1.
  - pop only: count-1.
  - push and pop in the same cycle: count unchanged, both pointers advance.
- Full queue:
  - in_ready=0, so no push occurs even if `adv` is asserted in the same cycle. in_ready does not depend on adv, so there is no combinational path from adv to in_ready.
  - in_ready becomes 1 the cycle after the pop.
- Flush:
  - Next edge: wptr=rptr=count=0.
  - Any push or pop in the same cycle is discarded; flush has priority.
  - Memory contents are not cleared. The outputs read zero because out_valid=0.
- Decode:
  - All field outputs are combinational slices of `out`.
  - When the queue is empty, every field output is 0.
- Reset (asserted asynchronously at any time, including mid-fill):
  - Immediately sets wptr=rptr=count=0.
  - Immediately clears all memory entries to 0.
  - Resulting outputs: out=0, out_valid=0, in_ready=1, count=0, all fields 0.

## Timing
- Load latency: a word pushed at edge N into an empty queue appears on out/fields after edge N, i.e. in cycle N+1. There is no combinational bypass from in to out.
- Pop latency: after a pop at edge N, the next entry, or zeros if the queue is now empty, appears in cycle N+1.
- Steady state: one push and one pop per cycle sustain full throughput at any count from 1 to DEPTH-1.
- in_ready, out_valid and count are registered-state functions. They change only on clk edges or on the asynchronous assertion of rst.
- Reset release: the first push can occur on the first rising edge with rst=0.

## Test plan
- Reset: assert rst with in=16'h6AB3 and in_valid=1 -> out=0, all fields 0, count=0, in_ready=1, out_valid=0. Nothing loads while rst=1.
- Single load/decode (defaults): push 16'b0110101010110011.
  - Required next cycle: opcode=6'b011010, RA=1, BA=10'b1010110011, IMM=9'b010110011, RA_stack=2'b10, imm_sext=16'h00B3.
  - Hold in_valid=0 and adv=0 for 3 cycles -> all outputs unchanged.
- Fill to full: push 16'h1001–16'h1004 -> count=4, in_ready=0.
  - Attempt to push 16'h1005 with adv=1 -> 16'h1005 is not stored, count=3, head=16'h1002.
- Wrap-around: with count at 3, run 8 cycles of simultaneous push/pop with an incrementing data sequence -> count stays 3, output order matches input order across the pointer wrap, imm_sext negative for IMM with MSB=1 (e.g. IMM=9'h1FF -> 16'hFFFF).
- Flush: at count=2, assert flush together with in_valid=1 and adv=1 -> next cycle count=0, out_valid=0, out=0.
  - The following push is visible at the head one cycle later.
- Reset mid-operation: assert rst asynchronously between edges at count=3 -> count, out and out_valid drop to 0 before the next clk edge.
  - Normal pushes resume after release.
